sram_delay_scheduler: RTL

Sequences all accesses to the shared external async SRAM (20-bit address, 16-bit DQ) that backs the pedal board's delay/echo circular buffer.
On each audio sample strobe it performs one write of the incoming sample, then one read per delay tap. It returns the tap samples to the effect datapath with a single valid pulse.
It sits between the sample-rate datapath and the SRAM pins. It is the only driver of SRAM_ADDR, SRAM_DQ and the SRAM control pins.

---
 rtl/pedal_pkg.sv | 16 +
 rtl/sram_delay_scheduler_if.sv | 30 +++
 rtl/delay_addr_calc.sv | 37 +++
 rtl/sram_delay_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared constants and state encoding for the pedal board SRAM delay path.
package pedal_pkg;

    localparam int SRAM_ADDR_W     = 20;
    localparam int SAMPLE_W        = 16;
    localparam int DEFAULT_ACC_CYC = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        TURN  = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } sram_sched_state_t;

endpackage

// File: rtl/sram_delay_scheduler_if.sv
// Sample-side bus between the effect datapath and the SRAM delay scheduler.
interface sram_delay_scheduler_if
    import pedal_pkg::*;
#(
    parameter int NUM_TAPS = 2,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SAMPLE_W
);

    logic                       enable;
    logic                       sample_strobe;
    logic [DATA_W-1:0]          wr_data;
    logic [ADDR_W-1:0]          buf_len;
    logic [NUM_TAPS*ADDR_W-1:0] tap_delay;
    logic [NUM_TAPS*DATA_W-1:0] tap_data;
    logic                       tap_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output enable, sample_strobe, wr_data, buf_len, tap_delay,
        input  tap_data, tap_valid, busy, overrun
    );

    modport slave (
        input  enable, sample_strobe, wr_data, buf_len, tap_delay,
        output tap_data, tap_valid, busy, overrun
    );

endinterface

// File: rtl/delay_addr_calc.sv
// Read address for one delay tap: clamp the delay to the buffer and wrap
// the pointer subtraction back into the circular buffer.
module delay_addr_calc
    import pedal_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] d,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int LW = ADDR_W + 1;

    logic [ADDR_W:0] d_clamp;
    logic [ADDR_W:0] sum;

    // len is never zero here: a zero buffer length arrives already expanded
    // to 2^ADDR_W, so len-1 is always a legal delay.
    always_comb begin
        if ({1'b0, d} >= len) begin
            d_clamp = len - LW'(1);
        end else begin
            d_clamp = {1'b0, d};
        end

        if ({1'b0, wr_ptr} >= d_clamp) begin
            sum = {1'b0, wr_ptr} - d_clamp;
        end else begin
            sum = {1'b0, wr_ptr} + len - d_clamp;
        end

        rd_addr = ADDR_W'(sum);
    end

endmodule

// File: rtl/sram_delay_scheduler.sv
// Sole owner of the external async SRAM: one sample write followed by one
// read per delay tap on every accepted audio sample strobe.
//
// state | meaning
// IDLE  | bus parked, waiting for an enabled sample strobe
// WRITE | ACC_CYC cycles driving the new sample at wr_ptr, WE_N low
// TURN  | one cycle data hold after WE_N rises, then DQ is released
// READ  | ACC_CYC cycles per tap, OE_N low, DQ sampled on the last cycle
// DONE  | publish all taps with tap_valid, advance wr_ptr on exit
module sram_delay_scheduler
    import pedal_pkg::*;
#(
    parameter int NUM_TAPS = 2,
    parameter int ACC_CYC  = DEFAULT_ACC_CYC,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SAMPLE_W
) (
    input  logic                  Clk,
    input  logic                  RESET_N,
    sram_delay_scheduler_if.slave bus,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    inout  wire  [DATA_W-1:0]     SRAM_DQ,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_WRITE = 3'(WRITE);
    localparam logic [2:0] S_TURN  = 3'(TURN);
    localparam logic [2:0] S_READ  = 3'(READ);
    localparam logic [2:0] S_DONE  = 3'(DONE);

    localparam int LW    = ADDR_W + 1;
    localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYC - 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    logic [2:0]                 state;
    logic [CNT_W-1:0]           acc_cnt;
    logic [TAP_W-1:0]           tap_idx;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          wr_ptr_next;
    logic [LW-1:0]              len_lat;
    logic [NUM_TAPS*ADDR_W-1:0] delay_lat;
    logic [NUM_TAPS*DATA_W-1:0] tap_shadow;
    logic [NUM_TAPS*DATA_W-1:0] tap_next;
    logic [NUM_TAPS*DATA_W-1:0] tap_data_q;
    logic                       tap_valid_q;
    logic                       busy_q;
    logic                       overrun_q;
    logic [DATA_W-1:0]          dq_out;
    logic                       dq_oe;
    logic [TAP_W-1:0]           calc_idx;
    logic [ADDR_W-1:0]          calc_delay;
    logic [ADDR_W-1:0]          calc_addr;
    logic                       acc_last;
    logic                       strobe_ok;
    logic [LW-1:0]              len_in;

    assign acc_last  = (acc_cnt == '0);
    assign strobe_ok = bus.sample_strobe && bus.enable;
    assign len_in    = (bus.buf_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, bus.buf_len};

    // The address calculator always looks one tap ahead: in TURN it prepares
    // tap 0, in READ k it prepares tap k+1 for the access boundary.
    always_comb begin
        calc_idx = '0;
        if (state == S_READ) begin
            calc_idx = tap_idx + TAP_W'(1);
        end
    end

    // Select the latched delay for the tap being prepared.
    always_comb begin
        calc_delay = delay_lat[0 +: ADDR_W];
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (calc_idx == TAP_W'(k)) begin
                calc_delay = delay_lat[k*ADDR_W +: ADDR_W];
            end
        end
    end

    delay_addr_calc #(
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .wr_ptr  (wr_ptr),
        .d       (calc_delay),
        .len     (len_lat),
        .rd_addr (calc_addr)
    );

    // Shadow tap registers with the current read's DQ merged into its slot.
    always_comb begin
        tap_next = tap_shadow;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (tap_idx == TAP_W'(k)) begin
                tap_next[k*DATA_W +: DATA_W] = SRAM_DQ;
            end
        end
    end

    // Pointer advance; a pointer left beyond a shrunk buffer restarts at 0.
    always_comb begin
        if (({1'b0, wr_ptr} + LW'(1)) >= len_lat) begin
            wr_ptr_next = '0;
        end else begin
            wr_ptr_next = wr_ptr + ADDR_W'(1);
        end
    end

    // Sequencer: state, counters, latches and registered SRAM pin values.
    always_ff @(posedge Clk) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            acc_cnt     <= '0;
            tap_idx     <= '0;
            wr_ptr      <= '0;
            len_lat     <= '0;
            delay_lat   <= '0;
            tap_shadow  <= '0;
            tap_data_q  <= '0;
            tap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (strobe_ok) begin
                        state     <= S_WRITE;
                        busy_q    <= 1'b1;
                        len_lat   <= len_in;
                        delay_lat <= bus.tap_delay;
                        acc_cnt   <= ACC_LOAD;
                        dq_out    <= bus.wr_data;
                        dq_oe     <= 1'b1;
                        SRAM_ADDR <= wr_ptr;
                        SRAM_CE_N <= 1'b0;
                        SRAM_WE_N <= 1'b0;
                        SRAM_OE_N <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (acc_last) begin
                        state     <= S_TURN;
                        SRAM_WE_N <= 1'b1;
                    end else begin
                        acc_cnt <= acc_cnt - CNT_W'(1);
                    end
                end
                S_TURN: begin
                    state     <= S_READ;
                    tap_idx   <= '0;
                    acc_cnt   <= ACC_LOAD;
                    dq_oe     <= 1'b0;
                    SRAM_OE_N <= 1'b0;
                    SRAM_ADDR <= calc_addr;
                end
                S_READ: begin
                    if (acc_last) begin
                        tap_shadow <= tap_next;
                        if (tap_idx == LAST_TAP) begin
                            state       <= S_DONE;
                            tap_data_q  <= tap_next;
                            tap_valid_q <= 1'b1;
                            SRAM_CE_N   <= 1'b1;
                            SRAM_OE_N   <= 1'b1;
                        end else begin
                            tap_idx   <= tap_idx + TAP_W'(1);
                            acc_cnt   <= ACC_LOAD;
                            SRAM_ADDR <= calc_addr;
                        end
                    end else begin
                        acc_cnt <= acc_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    tap_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    wr_ptr      <= wr_ptr_next;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: any strobe outside IDLE is dropped and flagged.
    always_ff @(posedge Clk) begin
        if (!RESET_N) begin
            overrun_q <= 1'b0;
        end else if (bus.sample_strobe && (state != S_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {DATA_W{1'bz}};
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;

    assign bus.tap_data  = tap_data_q;
    assign bus.tap_valid = tap_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule
